stack_alu_engine: RTL and testbench

Responder side of the calculator's ALU opcode stream: accepts `opcode`/`input_data` commands from the calculator sequencer, executes them against an internal operand stack, and reports top-of-stack, overflow and error status. Push, pop and add complete in one cycle. Multiply is a multi-cycle shift-add, so the block back-pressures the sequencer with a valid/ready handshake.

---
 rtl/stack_alu_pkg.sv | 20 ++
 rtl/seq_mult_unsigned.sv | 77 +++++++
 rtl/stack_alu_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_stack_alu_engine.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/stack_alu_pkg.sv
// Shared definitions for the calculator ALU opcode stream: opcodes, FSM states and
// default sizing used by both the sequencer and stack_alu_engine.
package stack_alu_pkg;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefStackSize = 64;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StMulRun,
    StMulFin
  } alu_state_e;

endpackage

// File: rtl/seq_mult_unsigned.sv
// Shift-add unsigned multiplier: start loads the operands, then one partial-product
// iteration per cycle for Width cycles; done pulses the cycle after the last iteration.
module seq_mult_unsigned #(
  parameter int unsigned Width = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [Width-1:0]   a_i,
  input  logic [Width-1:0]   b_i,
  output logic               busy_o,
  output logic               last_o,
  output logic               done_o,
  output logic [2*Width-1:0] product_o
);

  localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;

  logic [2*Width-1:0] a_q, a_d;
  logic [Width-1:0]   b_q, b_d;
  logic [2*Width-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               last;

  assign last = busy_q && (cnt_q == CntW'(Width - 1));

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i) begin
      a_d    = {{Width{1'b0}}, a_i};
      b_d    = b_i;
      acc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d = acc_q + (b_q[0] ? a_q : '0);
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + CntW'(1);
      if (last) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o    = busy_q;
  assign last_o    = last;
  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule

// File: rtl/stack_alu_engine.sv
// Stack-based ALU responder: PUSH/POP/ADD/NOP retire in one cycle, MUL runs on a
// sequential shift-add unit unless STACK_ALU_FAST_MUL_EN selects a combinational multiplier.
module stack_alu_engine
  import stack_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned STACK_SIZE = DefStackSize
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [2:0]                      opcode,
  input  logic [DATA_WIDTH-1:0]           input_data,
  output logic [DATA_WIDTH-1:0]           output_data,
  output logic                            overflow,
  output logic                            error,
  output logic                            done,
  output logic [$clog2(STACK_SIZE+1)-1:0] depth
);

  localparam int unsigned W      = DATA_WIDTH;
  localparam int unsigned DepthW = $clog2(STACK_SIZE + 1);
  localparam int unsigned AddrW  = (STACK_SIZE > 1) ? $clog2(STACK_SIZE) : 1;

  logic [W-1:0]      mem_q [STACK_SIZE];
  logic              mem_we;
  logic [AddrW-1:0]  mem_waddr;
  logic [W-1:0]      mem_wdata;

  logic [DepthW-1:0] depth_q, depth_d;
  logic [W-1:0]      out_q, out_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic [AddrW-1:0]  top_idx, nxt_idx;
  logic [W-1:0]      top_val, nxt_val;
  logic [W-1:0]      sum;
  logic              add_ovf;
  logic [2*W-1:0]    mul_full;
  logic              mul_ovf;
  logic              accept;

  // Indices wrap harmlessly when depth is too small; those reads are never used.
  assign top_idx = AddrW'(depth_q - DepthW'(1));
  assign nxt_idx = AddrW'(depth_q - DepthW'(2));
  assign top_val = mem_q[top_idx];
  assign nxt_val = mem_q[nxt_idx];

  assign sum     = nxt_val + top_val;
  assign add_ovf = (nxt_val[W-1] == top_val[W-1]) && (sum[W-1] != nxt_val[W-1]);

  // Product fits iff its upper half plus the result sign bit are all equal.
  assign mul_ovf = !((&mul_full[2*W-1:W-1]) || !(|mul_full[2*W-1:W-1]));

`ifdef STACK_ALU_FAST_MUL_EN
  logic signed [W-1:0]   mul_a_s, mul_b_s;
  logic signed [2*W-1:0] mul_prod_s;

  assign mul_a_s    = nxt_val;
  assign mul_b_s    = top_val;
  assign mul_prod_s = mul_a_s * mul_b_s;
  assign mul_full   = mul_prod_s;
  assign in_ready   = rst_n;
`else
  alu_state_e     state_q, state_d;
  logic           mul_neg_q, mul_neg_d;
  logic           mul_start, mul_busy, mul_last, mul_done;
  logic [W-1:0]   mag_a, mag_b;
  logic [2*W-1:0] mul_prod;

  assign mag_a    = nxt_val[W-1] ? (~nxt_val + W'(1)) : nxt_val;
  assign mag_b    = top_val[W-1] ? (~top_val + W'(1)) : top_val;
  assign mul_full = mul_neg_q ? (~mul_prod + (2*W)'(1)) : mul_prod;
  assign in_ready = rst_n && (state_q == StIdle);

  seq_mult_unsigned #(
    .Width(W)
  ) u_mult (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (mul_start),
    .a_i      (mag_a),
    .b_i      (mag_b),
    .busy_o   (mul_busy),
    .last_o   (mul_last),
    .done_o   (mul_done),
    .product_o(mul_prod)
  );
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    depth_d   = depth_q;
    out_d     = out_q;
    ovf_d     = ovf_q;
    err_d     = 1'b0;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
`ifndef STACK_ALU_FAST_MUL_EN
    state_d   = state_q;
    mul_neg_d = mul_neg_q;
    mul_start = 1'b0;
`endif
    if (accept) begin
      case (opcode)
        OP_NOP: done_d = 1'b1;
        OP_PUSH: begin
          if (depth_q == DepthW'(STACK_SIZE)) begin
            err_d = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = AddrW'(depth_q);
            mem_wdata = input_data;
            depth_d   = depth_q + DepthW'(1);
            out_d     = input_data;
            done_d    = 1'b1;
          end
        end
        OP_POP: begin
          if (depth_q == '0) begin
            err_d = 1'b1;
          end else begin
            depth_d = depth_q - DepthW'(1);
            out_d   = (depth_q >= DepthW'(2)) ? nxt_val : '0;
            done_d  = 1'b1;
          end
        end
        OP_ADD: begin
          if (depth_q < DepthW'(2)) begin
            err_d = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = nxt_idx;
            mem_wdata = sum;
            depth_d   = depth_q - DepthW'(1);
            out_d     = sum;
            ovf_d     = add_ovf;
            done_d    = 1'b1;
          end
        end
        OP_MUL: begin
          if (depth_q < DepthW'(2)) begin
            err_d = 1'b1;
          end else begin
`ifdef STACK_ALU_FAST_MUL_EN
            mem_we    = 1'b1;
            mem_waddr = nxt_idx;
            mem_wdata = mul_full[W-1:0];
            depth_d   = depth_q - DepthW'(1);
            out_d     = mul_full[W-1:0];
            ovf_d     = mul_ovf;
            done_d    = 1'b1;
`else
            state_d   = StMulRun;
            mul_start = 1'b1;
            mul_neg_d = nxt_val[W-1] ^ top_val[W-1];
`endif
          end
        end
        default: err_d = 1'b1;
      endcase
    end
`ifndef STACK_ALU_FAST_MUL_EN
    case (state_q)
      StMulRun: begin
        if (mul_last || !mul_busy) state_d = StMulFin;
      end
      StMulFin: begin
        state_d = StIdle;
        if (mul_done) begin
          mem_we    = 1'b1;
          mem_waddr = nxt_idx;
          mem_wdata = mul_full[W-1:0];
          depth_d   = depth_q - DepthW'(1);
          out_d     = mul_full[W-1:0];
          ovf_d     = mul_ovf;
          done_d    = 1'b1;
        end
      end
      default: ;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q   <= '0;
      out_q     <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
`ifndef STACK_ALU_FAST_MUL_EN
      state_q   <= StIdle;
      mul_neg_q <= 1'b0;
`endif
    end else begin
      depth_q   <= depth_d;
      out_q     <= out_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      done_q    <= done_d;
`ifndef STACK_ALU_FAST_MUL_EN
      state_q   <= state_d;
      mul_neg_q <= mul_neg_d;
`endif
    end
  end

  // Stack storage needs no reset; depth alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign output_data = out_q;
  assign overflow    = ovf_q;
  assign error       = err_q;
  assign done        = done_q;
  assign depth       = depth_q;

endmodule

// File: tb/tb_stack_alu_engine.sv
// Directed bench for stack_alu_engine at default sizing (16-bit data, 64 entries).
module tb_stack_alu_engine;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  opcode;
  logic [15:0] input_data;
  logic [15:0] output_data;
  logic        overflow;
  logic        error;
  logic        done;
  logic [6:0]  depth;

  int errors;
  int checks;

  stack_alu_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .input_data (input_data),
    .output_data(output_data),
    .overflow   (overflow),
    .error      (error),
    .done       (done),
    .depth      (depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge; returns at the next falling edge, after the accepting edge.
  task automatic cmd(input logic [2:0] op, input logic [15:0] data);
    in_valid   = 1'b1;
    opcode     = op;
    input_data = data;
    @(negedge clk);
    in_valid   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    opcode = 3'b000;
    input_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_low: got %b want 0", in_ready); end
    checks++; if (depth !== 7'd0) begin errors++; $display("FAIL rst_depth: got %0d want 0", depth); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_high: got %b want 1", in_ready); end
    @(negedge clk);
    checks++; if (output_data !== 16'h0) begin errors++; $display("FAIL rst_out: got %h want 0000", output_data); end
    checks++; if ({overflow, error, done} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {overflow, error, done}); end
  endtask

  task automatic test_add();
    cmd(3'b110, 16'd3);
    checks++; if (done !== 1'b1 || output_data !== 16'd3 || depth !== 7'd1) begin errors++; $display("FAIL push3: done=%b out=%h depth=%0d want 1/0003/1", done, output_data, depth); end
    cmd(3'b110, 16'd4);
    checks++; if (done !== 1'b1 || output_data !== 16'd4 || depth !== 7'd2) begin errors++; $display("FAIL push4: done=%b out=%h depth=%0d want 1/0004/2", done, output_data, depth); end
    cmd(3'b100, 16'd0);
    checks++; if (done !== 1'b1 || output_data !== 16'd7 || depth !== 7'd1 || overflow !== 1'b0) begin errors++; $display("FAIL add_3_4: done=%b out=%h depth=%0d ovf=%b want 1/0007/1/0", done, output_data, depth, overflow); end
    cmd(3'b111, 16'd0);
    checks++; if (output_data !== 16'd0 || depth !== 7'd0) begin errors++; $display("FAIL pop_empty_out: out=%h depth=%0d want 0000/0", output_data, depth); end
  endtask

  task automatic test_mul();
    int busy;
    logic done_seen;
    cmd(3'b110, 16'd7);
    cmd(3'b110, 16'hFFFA);
    cmd(3'b101, 16'd0);
    busy = 0;
    done_seen = 1'b0;
    while (in_ready === 1'b0 && busy < 40) begin
      if (done === 1'b1) done_seen = 1'b1;
      busy++;
      @(negedge clk);
    end
    checks++; if (busy !== 17) begin errors++; $display("FAIL mul_busy_cycles: got %0d want 17", busy); end
    checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL mul_early_done: got %b want 0", done_seen); end
    checks++; if (done !== 1'b1 || output_data !== 16'hFFD6 || depth !== 7'd1 || overflow !== 1'b0) begin errors++; $display("FAIL mul_7_m6: done=%b out=%h depth=%0d ovf=%b want 1/ffd6/1/0", done, output_data, depth, overflow); end
    cmd(3'b111, 16'd0);
    checks++; if (depth !== 7'd0) begin errors++; $display("FAIL mul_pop: depth=%0d want 0", depth); end
  endtask

  task automatic test_overflow();
    int busy;
    cmd(3'b110, 16'h7FFF);
    cmd(3'b110, 16'h0001);
    cmd(3'b100, 16'd0);
    checks++; if (output_data !== 16'h8000 || overflow !== 1'b1 || depth !== 7'd1) begin errors++; $display("FAIL add_ovf: out=%h ovf=%b depth=%0d want 8000/1/1", output_data, overflow, depth); end
    cmd(3'b110, 16'd2);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b want 1", overflow); end
    cmd(3'b110, 16'd3);
    cmd(3'b100, 16'd0);
    checks++; if (output_data !== 16'd5 || overflow !== 1'b0 || depth !== 7'd2) begin errors++; $display("FAIL add_clear_ovf: out=%h ovf=%b depth=%0d want 0005/0/2", output_data, overflow, depth); end
    cmd(3'b111, 16'd0);
    cmd(3'b111, 16'd0);
    cmd(3'b110, 16'h8000);
    cmd(3'b110, 16'hFFFF);
    cmd(3'b101, 16'd0);
    busy = 0;
    while (in_ready === 1'b0 && busy < 40) begin
      busy++;
      @(negedge clk);
    end
    checks++; if (busy !== 17 || output_data !== 16'h8000 || overflow !== 1'b1 || depth !== 7'd1) begin errors++; $display("FAIL mul_ovf: busy=%0d out=%h ovf=%b depth=%0d want 17/8000/1/1", busy, output_data, overflow, depth); end
  endtask

  task automatic test_errors();
    cmd(3'b100, 16'd0);
    checks++; if (error !== 1'b1 || done !== 1'b0 || output_data !== 16'h8000 || depth !== 7'd1 || overflow !== 1'b1) begin errors++; $display("FAIL add_underflow: err=%b done=%b out=%h depth=%0d ovf=%b want 1/0/8000/1/1", error, done, output_data, depth, overflow); end
    @(negedge clk);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %b want 0", error); end
    cmd(3'b010, 16'd0);
    checks++; if (error !== 1'b1 || done !== 1'b0 || depth !== 7'd1) begin errors++; $display("FAIL illegal_op: err=%b done=%b depth=%0d want 1/0/1", error, done, depth); end
    cmd(3'b101, 16'd0);
    checks++; if (error !== 1'b1 || in_ready !== 1'b1 || output_data !== 16'h8000) begin errors++; $display("FAIL mul_underflow: err=%b ready=%b out=%h want 1/1/8000", error, in_ready, output_data); end
    cmd(3'b111, 16'd0);
    checks++; if (error !== 1'b0 || done !== 1'b1 || depth !== 7'd0 || overflow !== 1'b1) begin errors++; $display("FAIL pop_last: err=%b done=%b depth=%0d ovf=%b want 0/1/0/1", error, done, depth, overflow); end
    cmd(3'b111, 16'd0);
    checks++; if (error !== 1'b1 || depth !== 7'd0 || output_data !== 16'h0) begin errors++; $display("FAIL pop_empty: err=%b depth=%0d out=%h want 1/0/0000", error, depth, output_data); end
    cmd(3'b000, 16'd0);
    checks++; if (done !== 1'b1 || error !== 1'b0 || depth !== 7'd0) begin errors++; $display("FAIL nop: done=%b err=%b depth=%0d want 1/0/0", done, error, depth); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 64; i++) cmd(3'b110, 16'(i + 1));
    checks++; if (depth !== 7'd64 || output_data !== 16'd64) begin errors++; $display("FAIL fill: depth=%0d out=%h want 64/0040", depth, output_data); end
    cmd(3'b110, 16'hAAAA);
    checks++; if (error !== 1'b1 || done !== 1'b0 || depth !== 7'd64 || output_data !== 16'd64) begin errors++; $display("FAIL push_full: err=%b done=%b depth=%0d out=%h want 1/0/64/0040", error, done, depth, output_data); end
    cmd(3'b111, 16'd0);
    checks++; if (depth !== 7'd63 || output_data !== 16'd63) begin errors++; $display("FAIL pop_full: depth=%0d out=%h want 63/003f", depth, output_data); end
    cmd(3'b110, 16'h0055);
    checks++; if (done !== 1'b1 || depth !== 7'd64 || output_data !== 16'h0055) begin errors++; $display("FAIL push_refill: done=%b depth=%0d out=%h want 1/64/0055", done, depth, output_data); end
  endtask

  task automatic test_back_to_back();
    cmd(3'b100, 16'd0);
    checks++; if (done !== 1'b1 || output_data !== 16'h0094 || depth !== 7'd63) begin errors++; $display("FAIL b2b_add1: done=%b out=%h depth=%0d want 1/0094/63", done, output_data, depth); end
    cmd(3'b100, 16'd0);
    checks++; if (done !== 1'b1 || output_data !== 16'h00D2 || depth !== 7'd62) begin errors++; $display("FAIL b2b_add2: done=%b out=%h depth=%0d want 1/00d2/62", done, output_data, depth); end
    cmd(3'b100, 16'd0);
    checks++; if (done !== 1'b1 || output_data !== 16'h010F || depth !== 7'd61) begin errors++; $display("FAIL b2b_add3: done=%b out=%h depth=%0d want 1/010f/61", done, output_data, depth); end
  endtask

  task automatic test_reset_mid_mul();
    logic done_seen;
    logic ready_dropped;
    cmd(3'b110, 16'd2);
    cmd(3'b110, 16'd3);
    cmd(3'b101, 16'd0);
    repeat (4) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_mul_busy: ready=%b want 0", in_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0 || depth !== 7'd0 || output_data !== 16'h0 || done !== 1'b0) begin errors++; $display("FAIL mid_mul_rst: ready=%b depth=%0d out=%h done=%b want 0/0/0000/0", in_ready, depth, output_data, done); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    ready_dropped = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) done_seen = 1'b1;
      if (in_ready !== 1'b1) ready_dropped = 1'b1;
    end
    checks++; if (done_seen !== 1'b0 || ready_dropped !== 1'b0) begin errors++; $display("FAIL mul_abort: done_seen=%b ready_dropped=%b want 0/0", done_seen, ready_dropped); end
    checks++; if (depth !== 7'd0 || output_data !== 16'h0) begin errors++; $display("FAIL mul_abort_state: depth=%0d out=%h want 0/0000", depth, output_data); end
    cmd(3'b110, 16'd9);
    checks++; if (done !== 1'b1 || depth !== 7'd1 || output_data !== 16'd9) begin errors++; $display("FAIL post_abort_push: done=%b depth=%0d out=%h want 1/1/0009", done, depth, output_data); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_add();
    test_mul();
    test_overflow();
    test_errors();
    test_full();
    test_back_to_back();
    test_reset_mid_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
